// File: rtl/serial_divider_pkg.sv
// Shared types and constants for the serial radix-2 restoring divider.
package serial_divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    CALC  = 2'd2,
    FIXUP = 2'd3
  } state_e;

  localparam int XLEN_DEFAULT = 32;
  localparam int LAT_NORMAL   = XLEN_DEFAULT + 3;
  localparam int LAT_SPECIAL  = 3;

  // Special-case results, sliced to XLEN by the users.
  localparam logic [63:0] DIV0_QUOTIENT = '1;
  localparam logic [63:0] OVF_REMAINDER = '0;

endpackage

// File: rtl/serial_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, pick quotient bit.
module serial_divider_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_bit_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, divisor_i};
    // A clear sign bit means the trial subtraction did not borrow.
    q_bit_o = ~diff[XLEN+1];
    rem_o   = q_bit_o ? diff[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/serial_divider_core.sv
// Iterative signed/unsigned divider: SETUP handles signs and special cases,
// CALC produces one quotient bit per cycle, FIXUP applies signs and publishes results.
module serial_divider_core
  import serial_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            fini_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            div_by_zero_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic            sgn_q, neg_q_q, neg_r_q, fix_q, dbz_q;
  logic [XLEN-1:0] dvd_q, dvs_q, sh_q;
  logic [XLEN:0]   rem_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quot_q, remd_q;
  logic            dbz_out_q, fini_q;

  logic            dvd_neg, dvs_neg, is_div0, is_ovf;
  logic [XLEN-1:0] dvd_abs, dvs_abs;
  logic [XLEN:0]   step_rem;
  logic            step_q;

  always_comb begin
    dvd_neg = sgn_q & dvd_q[XLEN-1];
    dvs_neg = sgn_q & dvs_q[XLEN-1];
    dvd_abs = dvd_neg ? -dvd_q : dvd_q;
    dvs_abs = dvs_neg ? -dvs_q : dvs_q;
    is_div0 = (dvs_q == '0);
    is_ovf  = sgn_q && (dvd_q == INT_MIN) && (dvs_q == '1);
  end

  serial_divider_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .bit_i     (sh_q[XLEN-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // NOTE: sequential state uses non-blocking assignments only; the synchronous
  // reset clears every register so an aborted operation leaves no trace.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      sgn_q     <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      fix_q     <= 1'b0;
      dbz_q     <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      sh_q      <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      remd_q    <= '0;
      dbz_out_q <= 1'b0;
      fini_q    <= 1'b0;
    end else begin
      fini_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            sgn_q   <= signed_i;
            dvd_q   <= dividend_i;
            dvs_q   <= divisor_i;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          neg_q_q <= dvd_neg ^ dvs_neg;
          neg_r_q <= dvd_neg;
          dbz_q   <= is_div0;
          if (is_div0) begin
            sh_q    <= DIV0_QUOTIENT[XLEN-1:0];
            rem_q   <= {1'b0, dvd_q};
            fix_q   <= 1'b0;
            state_q <= FIXUP;
          end else if (is_ovf) begin
            sh_q    <= dvd_q;
            rem_q   <= {1'b0, OVF_REMAINDER[XLEN-1:0]};
            fix_q   <= 1'b0;
            state_q <= FIXUP;
          end else begin
            sh_q    <= dvd_abs;
            dvs_q   <= dvs_abs;
            rem_q   <= '0;
            cnt_q   <= CW'(XLEN - 1);
            fix_q   <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          // Dividend bits leave the top of sh_q as quotient bits enter the bottom.
          rem_q <= step_rem;
          sh_q  <= {sh_q[XLEN-2:0], step_q};
          if (cnt_q == '0) state_q <= FIXUP;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        FIXUP: begin
          quot_q    <= (fix_q && neg_q_q) ? -sh_q : sh_q;
          remd_q    <= (fix_q && neg_r_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
          dbz_out_q <= dbz_q;
          fini_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign fini_o        = fini_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = remd_q;
  assign div_by_zero_o = dbz_out_q;

endmodule
